// File: rtl/reg_mem_n_if.sv
// Request/response bundle for reg_mem_n: master drives requests and clr,
// slave returns registered read data, busy and reject pulses.
interface reg_mem_n_if #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
);
  logic              en;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] ip;
  logic              clr;
  logic [DATA_W-1:0] op;
  logic              op_valid;
  logic              busy;
  logic              rej;

  modport master (
    output en, rw, addr, ip, clr,
    input  op, op_valid, busy, rej
  );

  modport slave (
    input  en, rw, addr, ip, clr,
    output op, op_valid, busy, rej
  );
endinterface

// File: rtl/reg_mem_n.sv
// Single-port DEPTH x DATA_W register memory with registered read and a hardware clear sweep.
// Optional written-map flagging reads of never-written words: define REG_MEM_VLD_EN.
//
// state   | meaning
// S_IDLE  | accepting read/write requests
// S_CLEAR | zeroing mem[ptr] each cycle, requests rejected
module reg_mem_n #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  reg_mem_n_if.slave  bus
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam bit                POW2 = (DEPTH == (1 << ADDR_W));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic              op_valid_q, op_valid_d;
  logic              rej_q, rej_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  generate
    if (POW2) begin : g_pow2
      assign addr_ok = 1'b1;
    end else begin : g_npow2
      assign addr_ok = (bus.addr < ADDR_W'(DEPTH));
    end
  endgenerate

`ifdef REG_MEM_VLD_EN
  logic [DEPTH-1:0] vld_q, vld_d;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    op_valid_d = 1'b0;
    rej_d      = 1'b0;
    we         = 1'b0;
    waddr      = bus.addr;
    wdata      = bus.ip;
`ifdef REG_MEM_VLD_EN
    vld_d      = vld_q;
`endif
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        rej_d = bus.en;
        if (bus.clr) begin
          ptr_d = '0;
`ifdef REG_MEM_VLD_EN
          vld_d = '0;
`endif
        end else if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        if (bus.clr) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          rej_d   = bus.en;
`ifdef REG_MEM_VLD_EN
          vld_d   = '0;
`endif
        end else if (bus.en) begin
          if (!addr_ok) begin
            rej_d = 1'b1;
          end else if (bus.rw) begin
            we = 1'b1;
`ifdef REG_MEM_VLD_EN
            vld_d[bus.addr] = 1'b1;
`endif
          end else begin
            op_d       = mem_q[bus.addr];
            op_valid_d = 1'b1;
`ifdef REG_MEM_VLD_EN
            rej_d      = ~vld_q[bus.addr];
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      rej_q      <= 1'b0;
`ifdef REG_MEM_VLD_EN
      vld_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      rej_q      <= rej_d;
`ifdef REG_MEM_VLD_EN
      vld_q      <= vld_d;
`endif
    end
  end

  // Storage has no reset; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign bus.op       = op_q;
  assign bus.op_valid = op_valid_q;
  assign bus.busy     = (state_q == S_CLEAR);
  assign bus.rej      = rej_q;

endmodule

// File: tb/tb_reg_mem_n.sv
// Directed bench for reg_mem_n: DEPTH=8 main instance plus a DEPTH=5 instance for out-of-range addresses.
module tb_reg_mem_n;

`ifdef REG_MEM_VLD_EN
  localparam bit VLD = 1'b1;
`else
  localparam bit VLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_mem_n_if #(.DATA_W(16), .DEPTH(8)) b8 ();
  reg_mem_n_if #(.DATA_W(16), .DEPTH(5)) b5 ();

  reg_mem_n #(.DATA_W(16), .DEPTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  reg_mem_n #(.DATA_W(16), .DEPTH(5)) dut5 (.clk(clk), .reset(reset), .bus(b5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b8.en = 1'b0; b8.rw = 1'b0; b8.clr = 1'b0; b8.addr = '0; b8.ip = '0;
    b5.en = 1'b0; b5.rw = 1'b0; b5.clr = 1'b0; b5.addr = '0; b5.ip = '0;
  endtask

  // Counts further busy cycles on b8 starting from an already-seen count; bounded.
  task automatic count_busy8(input int start, output int n);
    n = start;
    for (int i = 0; i < 40 && b8.busy; i++) begin
      tick();
      if (b8.busy) n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b0 || b8.busy !== 1'b1) begin
      errors++; $display("FAIL reset_state op=%h vld=%b busy=%b exp 0000 0 1", b8.op, b8.op_valid, b8.busy);
    end
    count_busy8(1, n);
    checks++; if (n !== 8) begin
      errors++; $display("FAIL reset_busy_len got %0d exp 8", n);
    end
    for (int a = 0; a < 8; a++) begin
      b8.en = 1'b1; b8.rw = 1'b0; b8.addr = 3'(a);
      tick();
      checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b1 || b8.rej !== VLD) begin
        errors++; $display("FAIL reset_read[%0d] op=%h vld=%b rej=%b exp 0000 1 %b", a, b8.op, b8.op_valid, b8.rej, VLD);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_write_read();
    b8.en = 1'b1; b8.rw = 1'b1; b8.addr = 3'd3; b8.ip = 16'hA5A5;
    tick();
    checks++; if (b8.op_valid !== 1'b0 || b8.rej !== 1'b0) begin
      errors++; $display("FAIL write_ack vld=%b rej=%b exp 0 0", b8.op_valid, b8.rej);
    end
    b8.rw = 1'b0; b8.ip = 16'h0000;
    tick();
    checks++; if (b8.op !== 16'hA5A5 || b8.op_valid !== 1'b1 || b8.rej !== 1'b0) begin
      errors++; $display("FAIL read_after_write op=%h vld=%b rej=%b exp a5a5 1 0", b8.op, b8.op_valid, b8.rej);
    end
    idle();
    tick();
    checks++; if (b8.op !== 16'hA5A5 || b8.op_valid !== 1'b0) begin
      errors++; $display("FAIL op_hold op=%h vld=%b exp a5a5 0", b8.op, b8.op_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      b8.en = 1'b1; b8.rw = 1'b1; b8.addr = 3'(k); b8.ip = 16'h0100 + 16'(k);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      b8.en = 1'b1; b8.rw = 1'b0; b8.addr = 3'(k);
      tick();
      checks++; if (b8.op !== 16'h0100 + 16'(k) || b8.op_valid !== 1'b1 || b8.rej !== 1'b0) begin
        errors++; $display("FAIL b2b_read[%0d] op=%h vld=%b rej=%b exp %h 1 0", k, b8.op, b8.op_valid, b8.rej, 16'h0100 + 16'(k));
      end
    end
    idle();
    tick();
    checks++; if (b8.op_valid !== 1'b0 || b8.op !== 16'h0107) begin
      errors++; $display("FAIL b2b_end vld=%b op=%h exp 0 0107", b8.op_valid, b8.op);
    end
  endtask

  task automatic test_clear();
    int n;
    b8.clr = 1'b1;
    tick();
    checks++; if (b8.busy !== 1'b1 || b8.rej !== 1'b0) begin
      errors++; $display("FAIL clr_start busy=%b rej=%b exp 1 0", b8.busy, b8.rej);
    end
    b8.clr = 1'b0; b8.en = 1'b1; b8.rw = 1'b1; b8.addr = 3'd1; b8.ip = 16'h1234;
    tick();
    checks++; if (b8.rej !== 1'b1 || b8.busy !== 1'b1) begin
      errors++; $display("FAIL clr_write_rej rej=%b busy=%b exp 1 1", b8.rej, b8.busy);
    end
    idle();
    tick();
    checks++; if (b8.rej !== 1'b0) begin
      errors++; $display("FAIL rej_one_cycle rej=%b exp 0", b8.rej);
    end
    count_busy8(3, n);
    checks++; if (n !== 8) begin
      errors++; $display("FAIL clr_busy_len got %0d exp 8", n);
    end
    b8.en = 1'b1; b8.rw = 1'b0; b8.addr = 3'd1;
    tick();
    checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b1 || b8.rej !== VLD) begin
      errors++; $display("FAIL clr_read1 op=%h vld=%b rej=%b exp 0000 1 %b", b8.op, b8.op_valid, b8.rej, VLD);
    end
    b8.addr = 3'd7;
    tick();
    checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b1) begin
      errors++; $display("FAIL clr_read7 op=%h vld=%b exp 0000 1", b8.op, b8.op_valid);
    end
    idle();
    tick();
  endtask

  task automatic test_clr_priority_restart();
    int n;
    b8.en = 1'b1; b8.rw = 1'b1; b8.addr = 3'd5; b8.ip = 16'hC0DE;
    tick();
    b8.rw = 1'b0; b8.clr = 1'b1;
    tick();
    checks++; if (b8.rej !== 1'b1 || b8.op_valid !== 1'b0 || b8.busy !== 1'b1 || b8.op !== 16'h0000) begin
      errors++; $display("FAIL clr_priority rej=%b vld=%b busy=%b op=%h exp 1 0 1 0000", b8.rej, b8.op_valid, b8.busy, b8.op);
    end
    idle();
    tick();
    tick();
    b8.clr = 1'b1;
    tick();
    b8.clr = 1'b0;
    count_busy8(1, n);
    checks++; if (n !== 8) begin
      errors++; $display("FAIL clr_restart_len got %0d exp 8", n);
    end
    b8.en = 1'b1; b8.rw = 1'b0; b8.addr = 3'd5;
    tick();
    checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b1) begin
      errors++; $display("FAIL restart_read5 op=%h vld=%b exp 0000 1", b8.op, b8.op_valid);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_request();
    int n;
    b8.en = 1'b1; b8.rw = 1'b1; b8.addr = 3'd6; b8.ip = 16'h7777;
    tick();
    b8.rw = 1'b0;
    tick();
    b8.rw = 1'b1; b8.ip = 16'h9999;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b0 || b8.busy !== 1'b1 || b8.rej !== 1'b0) begin
      errors++; $display("FAIL reset_mid op=%h vld=%b busy=%b rej=%b exp 0000 0 1 0", b8.op, b8.op_valid, b8.busy, b8.rej);
    end
    count_busy8(1, n);
    b8.en = 1'b1; b8.rw = 1'b0; b8.addr = 3'd6;
    tick();
    checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b1 || n !== 8) begin
      errors++; $display("FAIL reset_mid_read op=%h vld=%b busy_len=%0d exp 0000 1 8", b8.op, b8.op_valid, n);
    end
    idle();
    tick();
  endtask

  task automatic test_written_map();
    b8.en = 1'b1; b8.rw = 1'b1; b8.addr = 3'd2; b8.ip = 16'h0055;
    tick();
    b8.rw = 1'b0;
    tick();
    checks++; if (b8.op !== 16'h0055 || b8.op_valid !== 1'b1 || b8.rej !== 1'b0) begin
      errors++; $display("FAIL map_read2 op=%h vld=%b rej=%b exp 0055 1 0", b8.op, b8.op_valid, b8.rej);
    end
    b8.addr = 3'd4;
    tick();
    checks++; if (b8.op !== 16'h0000 || b8.op_valid !== 1'b1 || b8.rej !== VLD) begin
      errors++; $display("FAIL map_read4 op=%h vld=%b rej=%b exp 0000 1 %b", b8.op, b8.op_valid, b8.rej, VLD);
    end
    idle();
    tick();
  endtask

  task automatic test_depth5();
    int n;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 1;
    for (int i = 0; i < 40 && b5.busy; i++) begin
      tick();
      if (b5.busy) n++;
    end
    checks++; if (n !== 5) begin
      errors++; $display("FAIL d5_busy_len got %0d exp 5", n);
    end
    b5.en = 1'b1; b5.rw = 1'b1; b5.addr = 3'd4; b5.ip = 16'hBEEF;
    tick();
    checks++; if (b5.rej !== 1'b0) begin
      errors++; $display("FAIL d5_write4 rej=%b exp 0", b5.rej);
    end
    b5.rw = 1'b0;
    tick();
    checks++; if (b5.op !== 16'hBEEF || b5.op_valid !== 1'b1) begin
      errors++; $display("FAIL d5_read4 op=%h vld=%b exp beef 1", b5.op, b5.op_valid);
    end
    b5.rw = 1'b1; b5.addr = 3'd6; b5.ip = 16'h1111;
    tick();
    checks++; if (b5.rej !== 1'b1 || b5.op_valid !== 1'b0) begin
      errors++; $display("FAIL d5_write6 rej=%b vld=%b exp 1 0", b5.rej, b5.op_valid);
    end
    b5.rw = 1'b0;
    tick();
    checks++; if (b5.rej !== 1'b1 || b5.op_valid !== 1'b0 || b5.op !== 16'hBEEF) begin
      errors++; $display("FAIL d5_read6 rej=%b vld=%b op=%h exp 1 0 beef", b5.rej, b5.op_valid, b5.op);
    end
    b5.addr = 3'd4;
    tick();
    checks++; if (b5.rej !== 1'b0 || b5.op_valid !== 1'b1 || b5.op !== 16'hBEEF) begin
      errors++; $display("FAIL d5_reread4 rej=%b vld=%b op=%h exp 0 1 beef", b5.rej, b5.op_valid, b5.op);
    end
    idle();
    tick();
    checks++; if (b5.rej !== 1'b0 || b5.op_valid !== 1'b0) begin
      errors++; $display("FAIL d5_quiet rej=%b vld=%b exp 0 0", b5.rej, b5.op_valid);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_clr_priority_restart();
    test_reset_mid_request();
    test_written_map();
    test_depth5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
